// File: rtl/sum_frame_accumulator_if.sv
// rtl/sum_frame_accumulator_if.sv - sample-in / frame-result-out handshake bundle
interface sum_frame_accumulator_if #(
  parameter int IN_W  = 5,
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic [IN_W-1:0]  out_max;
  logic             out_overflow;

  // Driver of samples and consumer of frame results
  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_total, out_max, out_overflow
  );

  // The accumulator itself
  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_total, out_max, out_overflow
  );
endinterface

// File: rtl/sum_frame_accumulator.sv
// rtl/sum_frame_accumulator.sv - frame accumulator of adder sums: saturating total, max, overflow
module sum_frame_accumulator #(
  parameter int IN_W  = 5,
  parameter int ACC_W = 12,
  parameter int COUNT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  sum_frame_accumulator_if.slave  bus
);
  localparam int CNT_W = $clog2(COUNT + 1);
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [IN_W-1:0]  max_q, max_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [SUM_W-1:0] sum_ext;

  assign accept  = (state_q == S_ACCUM) && bus.in_valid;
  // One extra bit so the carry out of the total is visible for saturation
  assign sum_ext = {1'b0, total_q} + SUM_W'(bus.in_sum);

  // Next-state and datapath update; start only matters in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    max_d   = max_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          cnt_d   = '0;
          total_d = '0;
          max_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          cnt_d   = cnt_q + CNT_W'(1);
          total_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
          ovf_d   = ovf_q | sum_ext[ACC_W];
          max_d   = (bus.in_sum > max_q) ? bus.in_sum : max_q;
          if (cnt_q == CNT_W'(COUNT - 1)) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d == S_HOLD);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame datapath and registered result-valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      total_q     <= '0;
      max_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      max_q       <= max_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready     = (state_q == S_ACCUM);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_total    = total_q;
  assign bus.out_max      = max_q;
  assign bus.out_overflow = ovf_q;
  assign busy             = (state_q != S_IDLE);
endmodule
